// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl -- FIFO controller wrapped around an external simple
// dual-port RAM (port A write, port B read with a one-cycle data latency),
// with a 2-entry output buffer so the read side sustains 1 word/cycle.
//
// Ports
//   clk, rst_n              single rising-edge clock, async active-low reset
//   s_valid/s_ready/s_data  write-side handshake
//   m_valid/m_ready/m_data  read-side handshake, m_data registered
//   ram_ena/wea/addra/dia   RAM port-A write controls
//   ram_enb/addrb, ram_dob  RAM port-B read controls and returned data
//   level                   (only with DPRAM_FIFO_CTRL_LEVEL_EN) registered
//                           count of words held: RAM + in flight + buffered
//
// Build option: define DPRAM_FIFO_CTRL_LEVEL_EN to add the level port.
module dpram_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
  output logic [ADDR_W+1:0] level,
`endif
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dia,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_dob
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;

  logic [PW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d, occ;
  logic [1:0]                   buf_cnt_q, buf_cnt_d;
  logic [1:0][DATA_W-1:0]       buf_q, buf_d;
  logic                         inflight_q, inflight_d;
  logic                         acc, pop, issue;
  logic [2:0]                   in_use;

  // Pointers carry an extra wrap bit so full (DEPTH) and empty (0) differ.
  assign occ     = wptr_q - rptr_q;
  // rst_n gating keeps s_ready low while reset is held (registers read empty).
  assign s_ready = rst_n && (occ != PW'(DEPTH));
  assign acc     = s_valid && s_ready;
  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_q[0];
  assign pop     = m_valid && m_ready;

  // Issue only if the word will have a buffer slot when it lands; occupancy
  // comes from registered pointers so a word is never read in its write cycle.
  assign in_use  = 3'(buf_cnt_q) + 3'(inflight_q);
  assign issue   = (occ != '0) && ((in_use - 3'(pop)) < 3'd2);

  assign ram_ena   = acc;
  assign ram_wea   = acc;
  assign ram_addra = wptr_q[ADDR_W-1:0];
  assign ram_dia   = s_data;
  assign ram_enb   = issue;
  assign ram_addrb = rptr_q[ADDR_W-1:0];

  always_comb begin
    wptr_d     = wptr_q + PW'(acc);
    rptr_d     = rptr_q + PW'(issue);
    inflight_d = issue;
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;
    // Pop shifts first, then the returning RAM word lands in the next free slot.
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      buf_d[buf_cnt_d[0]] = ram_dob;
      buf_cnt_d           = buf_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      buf_cnt_q  <= '0;
      buf_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_q      <= buf_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
  localparam int LW = ADDR_W + 2;
  logic [LW-1:0] level_q, level_d;

  // Computed from next-state values so level tracks the words held right now.
  always_comb begin
    level_d = LW'(wptr_d - rptr_d) + LW'(inflight_d) + LW'(buf_cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM, queue reference model,
// directed latency/throughput/full/reset scenarios plus a random soak.
module tb_dpram_fifo_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, m_valid, m_ready;
  logic [DATA_W-1:0] s_data, m_data;
  logic              ram_ena, ram_wea, ram_enb;
  logic [ADDR_W-1:0] ram_addra, ram_addrb;
  logic [DATA_W-1:0] ram_dia, ram_dob;
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
  logic [ADDR_W+1:0] level;
`endif

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
    .level(level),
`endif
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  // Behavioural RAM: registered read address, data valid the next cycle.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int n_cmp = 0, n_err = 0;
  int pushes = 0, pops = 0;
  logic [DATA_W-1:0] q[$];
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observe one cycle mid-period and update the reference model.
  task automatic sample();
    logic acc, pop;
    @(negedge clk);
    acc = s_valid && s_ready;
    pop = m_valid && m_ready;
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
    end
    if (rst_n) begin
      if (q.size() < DEPTH) chk("sready_room", s_ready, 1);
      chk("cap_bound", q.size() <= DEPTH + 2, 1);
      chk("mvalid_vs_model", m_valid && (q.size() == 0), 0);
    end
    chk("wea_acc", ram_wea, acc);
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
    chk("level", level, q.size());
`endif
    if (pop) begin
      if (q.size() == 0) chk("pop_empty", 1, 0);
      else chk("order", m_data, q.pop_front());
      pops++;
    end
    if (acc) begin
      chk("dia", ram_dia, s_data);
      q.push_back(s_data);
      pushes++;
    end
    prev_stall = m_valid && !m_ready && rst_n;
    prev_data  = m_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    s_valid = 0; m_ready = 1;
    while (q.size() > 0 && c < max_cyc) begin
      sample(); tick(); c++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    int base, c;
    rst_n = 0; s_valid = 0; m_ready = 0; s_data = '0;
    #1;
    sample();
    chk("rst_sready", s_ready, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_ena", ram_ena, 0);
    chk("rst_enb", ram_enb, 0);
    tick();
    rst_n = 1;

    // Single word latency.
    s_valid = 1; s_data = 16'hA5A5; m_ready = 1;
    sample();
    chk("c0_sready", s_ready, 1);
    chk("c0_wea", ram_wea, 1);
    chk("c0_ena", ram_ena, 1);
    chk("c0_addra", ram_addra, 0);
    chk("c0_enb", ram_enb, 0);
    tick();
    s_valid = 0;
    sample();
    chk("c1_enb", ram_enb, 1);
    chk("c1_addrb", ram_addrb, 0);
    chk("c1_ena", ram_ena, 0);
    chk("c1_mvalid", m_valid, 0);
    tick();
    sample();
    chk("c2_mvalid", m_valid, 0);
    chk("c2_enb", ram_enb, 0);
    tick();
    sample();
    chk("c3_mvalid", m_valid, 1);
    chk("c3_mdata", m_data, 16'hA5A5);
    tick();
    sample();
    chk("c4_mvalid", m_valid, 0);
    tick();

    // Streaming 0..199: accepted every cycle, output gapless from cycle 3.
    base = pops;
    for (int i = 0; i < 203; i++) begin
      s_valid = (i < 200);
      s_data  = DATA_W'(i);
      m_ready = 1;
      sample();
      if (i < 200) chk("stream_sready", s_ready, 1);
      chk("stream_mvalid", m_valid, (i >= 3) ? 1 : 0);
      tick();
    end
    s_valid = 0;
    chk("stream_count", pops - base, 200);

    // Fill until full with consumer stalled.
    base = pushes; c = 0;
    m_ready = 0; s_valid = 1;
    while (c < 120) begin
      s_data = DATA_W'($urandom);
      sample();
      if (!s_ready) break;
      tick(); c++;
    end
    chk("full_reached", s_ready, 0);
    chk("full_count", pushes - base, DEPTH + 2);
    tick();
    s_valid = 0; m_ready = 1;
    sample(); tick();
    sample();
    chk("sready_after_pop", s_ready, 1);
    tick();
    drain(200);

    // Random soak with stall-stability checks in sample().
    base = pushes; c = 0;
    while (pushes - base < 10000 && c < 60000) begin
      s_valid = $urandom_range(0, 1);
      s_data  = DATA_W'($urandom);
      m_ready = $urandom_range(0, 1);
      sample(); tick(); c++;
    end
    chk("rand_pushed", pushes - base, 10000);
    drain(200);

    // Reset mid-burst with 10 words stored.
    m_ready = 0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1; s_data = DATA_W'(16'h0100 + i);
      sample(); tick();
    end
    s_valid = 0;
    sample(); tick();
    sample();
    chk("pre_rst_mvalid", m_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_mvalid", m_valid, 0);
    chk("async_sready", s_ready, 0);
    chk("async_enb", ram_enb, 0);
    q.delete();
    prev_stall = 1'b0;
    tick();
    sample();
    tick();
    rst_n = 1;
    s_valid = 1; s_data = 16'h1234;
    sample(); tick();
    s_valid = 0; m_ready = 1;
    c = 0;
    while (!m_valid && c < 10) begin
      sample(); tick(); c++;
    end
    chk("post_rst_first", m_data, 16'h1234);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
